// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a pipeline request port and a
// word-wide data memory with combinational read data.
// Loads and word stores take one cycle each. Byte and halfword stores use a
// read-modify-write: read cycle in IDLE, then a write cycle in RMW_WR.
// Optional feature macro: MAU_MISALIGN_CHECK_EN
//   defined   -> misaligned halfword/word and size 2'b11 become error requests
//   undefined -> no error detection; size 2'b11 behaves as a word access
// Request handshake: a request transfers on a rising clk_i edge where
// req_valid_i and req_ready_o are both 1. req_ready_o is 1 only in IDLE, so a
// request held across RMW_WR transfers on the first edge back in IDLE.
// Response: rsp_valid_o is a single-cycle pulse with no back-pressure;
// rsp_err_o and rsp_rdata_o are qualified by it, and rsp_rdata_o holds its
// value until the next response.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              dbg_state_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic [31:0]       merge_word_q;
    logic [ADDR_W-1:0] merge_idx_q;

    logic              accept;
    logic              req_err;
    logic              is_word;
    logic              sub_store;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic [31:0]       merge_word;
    logic              rsp_fire;
    logic [31:0]       rdata_next;
    logic              err_next;

    // Upper address bits beyond the memory's word index are not decoded.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[31:ADDR_W+2];

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign is_word     = req_size_i[1];
    assign sub_store   = req_we_i && !is_word;
    assign dbg_state_o = state_q;

    // Error classification of the incoming request.
    always_comb begin
        req_err = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
        case (req_size_i)
            2'b01:   req_err = req_addr_i[0];
            2'b10:   req_err = (req_addr_i[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
`endif
    end

    // Lane selection and sign/zero extension of the memory read word.
    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = 16'h0000;
        load_data = mem_rdata_i;
        case (req_addr_i[1:0])
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = req_addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (req_size_i)
            2'b00:   load_data = {{24{!req_unsigned_i && ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{!req_unsigned_i && ld_half[15]}}, ld_half};
            default: load_data = mem_rdata_i;
        endcase
    end

    // Old word with the target byte/halfword lane replaced by store data.
    always_comb begin
        merge_word = mem_rdata_i;
        if (req_size_i == 2'b00) begin
            case (req_addr_i[1:0])
                2'd0:    merge_word[7:0]   = req_wdata_i[7:0];
                2'd1:    merge_word[15:8]  = req_wdata_i[7:0];
                2'd2:    merge_word[23:16] = req_wdata_i[7:0];
                default: merge_word[31:24] = req_wdata_i[7:0];
            endcase
        end else if (req_addr_i[1]) begin
            merge_word[31:16] = req_wdata_i[15:0];
        end else begin
            merge_word[15:0] = req_wdata_i[15:0];
        end
    end

    // Next state, memory port drive and response staging.
    always_comb begin
        state_d     = state_q;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = req_addr_i[ADDR_W+1:2];
        mem_wdata_o = req_wdata_i;
        rsp_fire    = 1'b0;
        rdata_next  = 32'h0;
        err_next    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_fire = 1'b1;
                        err_next = 1'b1;
                    end else if (!req_we_i) begin
                        mem_re_o   = 1'b1;
                        rsp_fire   = 1'b1;
                        rdata_next = load_data;
                    end else if (is_word) begin
                        mem_we_o = 1'b1;
                        rsp_fire = 1'b1;
                    end else begin
                        mem_re_o = 1'b1;
                        state_d  = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = merge_idx_q;
                mem_wdata_o = merge_word_q;
                rsp_fire    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset suppresses every memory access, including a pending RMW write.
        if (rst_i) begin
            mem_re_o = 1'b0;
            mem_we_o = 1'b0;
        end
    end

    // State, response and merge registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            merge_word_q <= 32'h0;
            merge_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_fire;
            if (rsp_fire) begin
                rsp_err_q   <= err_next;
                rsp_rdata_q <= rdata_next;
            end
            if (accept && sub_store && !req_err) begin
                merge_word_q <= merge_word;
                merge_idx_q  <= req_addr_i[ADDR_W+1:2];
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
`ifdef MAU_MISALIGN_CHECK_EN
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
    logic unused_err_q;
    assign unused_err_q = rsp_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit. Inputs change and outputs are
// sampled on the falling clock edge; the memory model writes on the rising
// edge and returns read data combinationally.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic              dbg_state_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_we_o       (mem_we_o),
        .mem_re_o       (mem_re_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .dbg_state_o    (dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Memory model
    assign mem_rdata_i = mem[mem_addr_o];
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
    endtask

    task automatic drive_idle();
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk_i);
        #1;
        if (mem_re_o !== 1'b0 || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL rst_mem_en got re=%b we=%b exp 0 0", mem_re_o, mem_we_o);
        end
        total++;
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== 34'h0) begin
            bad++; $display("FAIL rst_rsp got v=%b e=%b d=%h exp 0 0 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        total++;
        if (req_ready_o !== 1'b1 || dbg_state_o !== 1'b0) begin
            bad++; $display("FAIL rst_ready got rdy=%b st=%b exp 1 0", req_ready_o, dbg_state_o);
        end
        total++;
    endtask

    task automatic test_load_byte();
        @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        #1;
        if (mem_re_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 10'd4) begin
            bad++; $display("FAIL lb_port got re=%b we=%b idx=%0d exp 1 0 4", mem_re_o, mem_we_o, mem_addr_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFFFF88 || rsp_err_o !== 1'b0) begin
            bad++; $display("FAIL lb_rsp got v=%b d=%h e=%b exp 1 ffffff88 0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h00000088) begin
            bad++; $display("FAIL lbu_rsp got v=%b d=%h exp 1 00000088", rsp_valid_o, rsp_rdata_o);
        end
        total++;
        @(negedge clk_i);
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h00000088) begin
            bad++; $display("FAIL rdata_hold got v=%b d=%h exp 0 00000088", rsp_valid_o, rsp_rdata_o);
        end
        total++;
    endtask

    task automatic test_load_half();
        @(negedge clk_i);
        drive_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        @(negedge clk_i);
        drive_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h00008899) begin
            bad++; $display("FAIL lhu_rsp got v=%b d=%h exp 1 00008899", rsp_valid_o, rsp_rdata_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFFAABB) begin
            bad++; $display("FAIL lh_rsp got v=%b d=%h exp 1 ffffaabb", rsp_valid_o, rsp_rdata_o);
        end
        total++;
    endtask

    task automatic test_sub_store();
        @(negedge clk_i);
        drive_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
        #1;
        if (mem_re_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 10'd4) begin
            bad++; $display("FAIL sb_read got re=%b we=%b idx=%0d exp 1 0 4", mem_re_o, mem_we_o, mem_addr_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        #1;
        if (mem_we_o !== 1'b1 || mem_re_o !== 1'b0 || mem_wdata_o !== 32'h8899CCBB
            || mem_addr_o !== 10'd4) begin
            bad++; $display("FAIL sb_write got we=%b re=%b wd=%h idx=%0d exp 1 0 8899ccbb 4",
                            mem_we_o, mem_re_o, mem_wdata_o, mem_addr_o);
        end
        total++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || dbg_state_o !== 1'b1) begin
            bad++; $display("FAIL sb_busy got rdy=%b v=%b st=%b exp 0 0 1", req_ready_o, rsp_valid_o, dbg_state_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL sb_rsp got v=%b d=%h e=%b rdy=%b exp 1 0 0 1",
                            rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h8899CCBB) begin
            bad++; $display("FAIL lw_after_sb got v=%b d=%h exp 1 8899ccbb", rsp_valid_o, rsp_rdata_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        @(negedge clk_i);
        if (rsp_valid_o !== 1'b1 || mem[4] !== 32'h1234CCBB) begin
            bad++; $display("FAIL sh_merge got v=%b mem=%h exp 1 1234ccbb", rsp_valid_o, mem[4]);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        #1;
        if (mem_we_o !== 1'b1 || mem_re_o !== 1'b0 || mem_addr_o !== 10'd8
            || mem_wdata_o !== 32'h11111111 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL sw1_port got we=%b re=%b idx=%0d wd=%h rdy=%b exp 1 0 8 11111111 1",
                            mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, req_ready_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222);
        #1;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd9 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
            bad++; $display("FAIL sw2_port got we=%b idx=%0d rdy=%b v=%b exp 1 9 1 1",
                            mem_we_o, mem_addr_o, req_ready_o, rsp_valid_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || mem[8] !== 32'h11111111 || mem[9] !== 32'h22222222) begin
            bad++; $display("FAIL sw_pair got v=%b d=%h m8=%h m9=%h exp 1 0 11111111 22222222",
                            rsp_valid_o, rsp_rdata_o, mem[8], mem[9]);
        end
        total++;
        @(negedge clk_i);
        if (rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL sw_pulse_end got v=%b exp 0", rsp_valid_o);
        end
        total++;
    endtask

    task automatic test_misalign();
        @(negedge clk_i);
        drive_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        #1;
`ifdef MAU_MISALIGN_CHECK_EN
        if (mem_re_o !== 1'b0 || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL mis_port got re=%b we=%b exp 0 0", mem_re_o, mem_we_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
            bad++; $display("FAIL mis_rsp got v=%b e=%b d=%h exp 1 1 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin
            bad++; $display("FAIL size11_rsp got v=%b e=%b exp 1 1", rsp_valid_o, rsp_err_o);
        end
        total++;
`else
        if (mem_re_o !== 1'b1 || mem_addr_o !== 10'd4) begin
            bad++; $display("FAIL mis_port got re=%b idx=%0d exp 1 4", mem_re_o, mem_addr_o);
        end
        total++;
        @(negedge clk_i);
        drive_req(1'b0, 2'b11, 1'b0, 32'h13, 32'h0);
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1234CCBB) begin
            bad++; $display("FAIL mis_rsp got v=%b e=%b d=%h exp 1 0 1234ccbb", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        total++;
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1234CCBB) begin
            bad++; $display("FAIL size11_rsp got v=%b e=%b d=%h exp 1 0 1234ccbb", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        total++;
`endif
        // A clean response after an error clears the error flag.
        @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        @(negedge clk_i);
        drive_idle();
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h000000BB) begin
            bad++; $display("FAIL err_clear got v=%b e=%b d=%h exp 1 0 000000bb", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        total++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk_i);
        drive_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
        @(negedge clk_i);
        drive_idle();
        rst_i = 1'b1;
        #1;
        if (mem_we_o !== 1'b0 || mem_re_o !== 1'b0) begin
            bad++; $display("FAIL abort_port got we=%b re=%b exp 0 0", mem_we_o, mem_re_o);
        end
        total++;
        @(negedge clk_i);
        rst_i = 1'b0;
        if (mem[4] !== 32'h1234CCBB || dbg_state_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL abort_state got mem=%h st=%b v=%b exp 1234ccbb 0 0", mem[4], dbg_state_o, rsp_valid_o);
        end
        total++;
        @(negedge clk_i);
        if (rsp_valid_o !== 1'b0 || mem[4] !== 32'h1234CCBB) begin
            bad++; $display("FAIL abort_no_rsp got v=%b mem=%h exp 0 1234ccbb", rsp_valid_o, mem[4]);
        end
        total++;
        // Word store accepted in the same cycle as reset: no write, no response.
        drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        rst_i = 1'b1;
        @(negedge clk_i);
        drive_idle();
        rst_i = 1'b0;
        @(negedge clk_i);
        if (rsp_valid_o !== 1'b0 || mem[4] !== 32'h1234CCBB) begin
            bad++; $display("FAIL rst_accept got v=%b mem=%h exp 0 1234ccbb", rsp_valid_o, mem[4]);
        end
        total++;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        drive_idle();
        test_reset();
        test_load_byte();
        test_load_half();
        test_sub_store();
        test_back_to_back();
        test_misalign();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 10, word-index width of the data memory port.
REQ-002 Ports (clock and reset first):
- clk_i  in  1  single clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  pipeline request valid.
- req_ready_o  out  1  unit accepts a request this cycle.
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  2  00=byte, 01=half, 10=word, 11=reserved.
- req_unsigned_i  in  1  zero-extend loads when 1.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or reserved-size request; valid with rsp_valid_o.
- mem_we_o  out  1  data memory write enable.
- mem_re_o  out  1  data memory read enable.
- mem_addr_o  out  ADDR_W  word index = req_addr_i[ADDR_W+1:2].
- mem_wdata_o  out  32  word written to memory.
- mem_rdata_i  in  32  combinational read data from memory.

Function
REQ-003 Little-endian lanes: byte at addr[1:0]=n occupies bits 8n+7:8n; a halfword at addr[1]=h occupies bits 16h+15:16h.
REQ-004 A request is accepted when req_valid_i and req_ready_o are both 1 on a rising edge.
REQ-005 FSM states: IDLE, RMW_WR; req_ready_o=1 only in IDLE.
REQ-006 Load accepted in IDLE: mem_re_o=1 and mem_addr_o driven combinationally in the same cycle; the lane is selected, sign- or zero-extended, and registered; rsp_valid_o=1 the next cycle.
REQ-007 Word store accepted in IDLE: mem_we_o=1 with mem_wdata_o=req_wdata_i in the same cycle; state stays IDLE; rsp_valid_o=1 the next cycle.
REQ-008 Byte/half store accepted in IDLE: read cycle with mem_re_o=1; the merged word (old word with the target lane replaced by the low bits of req_wdata_i) and the word index are registered; transition to RMW_WR.
REQ-009 RMW_WR: mem_we_o=1 with the registered word and index, mem_re_o=0; return to IDLE; rsp_valid_o=1 the next cycle.
REQ-010 Back-to-back loads and word stores sustain one request per cycle; a sub-word store occupies two cycles.
REQ-011 Error request (REQ-016): no memory enable asserted; rsp_valid_o=1 and rsp_err_o=1 the next cycle; rsp_rdata_o=0.
REQ-012 mem_we_o and mem_re_o are never both 1, and both are 0 while rst_i=1.
REQ-013 rsp_rdata_o holds its value until the next response; rsp_err_o=0 on non-error responses.

Reset
REQ-014 On rst_i=1: state=IDLE, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, merge registers=0; req_ready_o=1 on the first cycle after reset release.
REQ-015 Reset asserted in RMW_WR aborts the pending write (no memory write occurs); reset in the cycle of a load or word-store accept produces no response.

Configuration
REQ-016 MAU_MISALIGN_CHECK_EN defined: a halfword with addr[0]=1, a word with addr[1:0]!=0, or size 11 is an error request handled per REQ-011.
REQ-017 MAU_MISALIGN_CHECK_EN undefined: rsp_err_o is tied 0; halfword uses addr[1] only, word ignores addr[1:0], size 11 is treated as word.

Verification (memory word 4 preloaded to 0x8899AABB)
REQ-018 LB addr 0x13 -> mem_re_o=1 with index 4 in the same cycle; next cycle rsp_valid_o=1, rsp_rdata_o=0xFFFFFF88.
REQ-019 LHU addr 0x12 -> rsp_rdata_o=0x00008899; LH addr 0x10 -> 0xFFFFAABB.
REQ-020 SB addr 0x11 wdata 0x000000CC -> cycle 1 read, cycle 2 mem_we_o=1 with wdata 0x8899CCBB and req_ready_o=0; rsp_valid_o in cycle 3; a subsequent LW 0x10 returns 0x8899CCBB.
REQ-021 SW 0x20 then SW 0x24 on consecutive cycles -> req_ready_o stays 1; two mem_we_o cycles; two rsp_valid_o pulses.
REQ-022 With the check enabled, LW 0x12 -> no mem_re_o, rsp_err_o=1, rsp_rdata_o=0; without it -> returns word 4.
REQ-023 SH 0x10 with rst_i asserted during RMW_WR -> word 4 unchanged, state IDLE, no rsp_valid_o.
